// File: rtl/shared_port_arbiter_if.sv
// Bundle of the requester-side and shared-port signals of the arbiter.
// The arbiter connects through the master modport; the surrounding
// producers and the sink drive and observe through the slave modport.
interface shared_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      m_valid;
    logic [DATA_W-1:0]         m_data;
    logic                      m_last;
    logic [SRC_W-1:0]          m_src;
    logic                      m_ready;
    logic [NUM_REQ-1:0]        grant_oh;
    logic                      busy;

    modport master (
        input  req_valid, req_last, req_data, m_ready,
        output req_ready, m_valid, m_data, m_last, m_src, grant_oh, busy
    );

    modport slave (
        output req_valid, req_last, req_data, m_ready,
        input  req_ready, m_valid, m_data, m_last, m_src, grant_oh, busy
    );
endinterface

// File: rtl/shared_port_arbiter.sv
// Burst-based round-robin arbiter sharing one valid/ready sink port among
// NUM_REQ producers. A grant lasts until the producer's last beat, a forced
// cap of MAX_BURST beats, or IDLE_TIMEOUT consecutive cycles with the
// granted producer's valid low. Every grant is followed by one IDLE cycle.
module shared_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 8,
    parameter int SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_port_arbiter_if.master bus
);
    // beat_cnt only has to reach MAX_BURST-1, so it can never wrap
    localparam int BCNT_W = $clog2(MAX_BURST) + 1;
    localparam int ICNT_W = $clog2(IDLE_TIMEOUT) + 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_oh, grant_oh_nxt;
    logic [SRC_W-1:0]   src, src_nxt;
    logic [SRC_W-1:0]   last_ptr, last_ptr_nxt;
    logic [BCNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic [ICNT_W-1:0]  idle_cnt, idle_cnt_nxt;

    logic               any_req;
    logic [SRC_W-1:0]   winner;
    int                 best;

    logic               g_valid;
    logic               g_last;
    logic [DATA_W-1:0]  g_data;
    logic               in_xfer;
    logic               beat_last;

    // Distance of requester idx from the highest-priority slot last_ptr+1,
    // so the nearest valid requester in rotating order has the smallest value.
    function automatic int rr_dist(input int idx, input int ptr);
        return (idx + NUM_REQ - 1 - ptr) % NUM_REQ;
    endfunction

    // Rotating-priority pick of the next winner among valid requesters
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        best    = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && (rr_dist(i, int'(last_ptr)) < best)) begin
                any_req = 1'b1;
                winner  = SRC_W'(i);
                best    = rr_dist(i, int'(last_ptr));
            end
        end
    end

    // Select the granted requester's signals; other requesters' data is never muxed through
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(src) == i) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_xfer   = (state == XFER);
    assign beat_last = g_valid && (g_last || (beat_cnt == BCNT_W'(MAX_BURST - 1)));

    assign bus.m_valid   = in_xfer && g_valid;
    assign bus.m_data    = in_xfer ? g_data : '0;
    assign bus.m_last    = in_xfer && beat_last;
    assign bus.req_ready = (in_xfer && bus.m_ready) ? grant_oh : '0;
    assign bus.m_src     = src;
    assign bus.grant_oh  = grant_oh;
    assign bus.busy      = in_xfer;

    // Next-state logic: arbitration in IDLE, burst/timeout tracking in XFER
    always_comb begin
        state_nxt    = state;
        grant_oh_nxt = grant_oh;
        src_nxt      = src;
        last_ptr_nxt = last_ptr;
        beat_cnt_nxt = beat_cnt;
        idle_cnt_nxt = idle_cnt;
        if (state == IDLE) begin
            if (any_req) begin
                state_nxt    = XFER;
                grant_oh_nxt = NUM_REQ'(1) << winner;
                src_nxt      = winner;
                last_ptr_nxt = winner;
                beat_cnt_nxt = '0;
                idle_cnt_nxt = '0;
            end
        end else if (bus.m_ready) begin
            // A stalled sink freezes everything, including the idle timer
            if (g_valid) begin
                idle_cnt_nxt = '0;
                if (beat_last) begin
                    state_nxt    = IDLE;
                    grant_oh_nxt = '0;
                end else begin
                    beat_cnt_nxt = beat_cnt + BCNT_W'(1);
                end
            end else if (idle_cnt == ICNT_W'(IDLE_TIMEOUT - 1)) begin
                state_nxt    = IDLE;
                grant_oh_nxt = '0;
            end else begin
                idle_cnt_nxt = idle_cnt + ICNT_W'(1);
            end
        end
    end

    // State register; last_ptr starts at the top index so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_oh <= '0;
            src      <= '0;
            last_ptr <= SRC_W'(NUM_REQ - 1);
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_oh <= grant_oh_nxt;
            src      <= src_nxt;
            last_ptr <= last_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end
endmodule
